// File: rtl/idli_sqi_arb_if.sv
// Core-side fetch/data request ports and SQI pin bundle for idli_sqi_arb.
// The slave modport is the controller's view; master is the requester/bench view.
interface idli_sqi_arb_if;
    logic        i_fetch_req;
    logic [15:0] i_fetch_addr;
    logic        o_fetch_gnt;
    logic        o_fetch_vld;
    logic [3:0]  o_fetch_data;
    logic        i_data_req;
    logic        i_data_wr;
    logic [15:0] i_data_addr;
    logic        o_data_gnt;
    logic        o_data_rdy;
    logic [3:0]  i_data_wdata;
    logic        o_data_vld;
    logic [3:0]  o_data_rdata;
    logic        o_sqi_cs_n;
    logic        o_sqi_sck_en;
    logic [3:0]  o_sqi_sio;
    logic        o_sqi_oe;
    logic [3:0]  i_sqi_sio;

    modport slave (
        input  i_fetch_req, i_fetch_addr, i_data_req, i_data_wr, i_data_addr,
               i_data_wdata, i_sqi_sio,
        output o_fetch_gnt, o_fetch_vld, o_fetch_data, o_data_gnt, o_data_rdy,
               o_data_vld, o_data_rdata, o_sqi_cs_n, o_sqi_sck_en, o_sqi_sio, o_sqi_oe
    );

    modport master (
        output i_fetch_req, i_fetch_addr, i_data_req, i_data_wr, i_data_addr,
               i_data_wdata, i_sqi_sio,
        input  o_fetch_gnt, o_fetch_vld, o_fetch_data, o_data_gnt, o_data_rdy,
               o_data_vld, o_data_rdata, o_sqi_cs_n, o_sqi_sck_en, o_sqi_sio, o_sqi_oe
    );
endinterface

// File: rtl/idli_sqi_arb.sv
// Round-robin arbiter and sequencer sharing one quad-SPI SRAM between the
// fetch and load/store requesters; one 4b slice per clock, 16b word per access.
module idli_sqi_arb #(
    parameter int DUMMY_CYCLES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    idli_sqi_arb_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

    state_t      r_state;
    state_t      w_nxt_state;
    logic [2:0]  r_phase;
    logic [2:0]  w_nxt_phase;
    logic        r_last_data;
    logic        r_sel_fetch;
    logic        r_wr;
    logic [15:0] r_addr;
    logic        r_fetch_gnt;
    logic        r_data_gnt;
    logic        r_fetch_vld;
    logic        r_data_vld;
    logic [3:0]  r_fetch_data;
    logic [3:0]  r_data_rdata;
    logic        w_grant;
    logic        w_pick_fetch;
    logic        w_rd_data;
    logic        w_active;
    logic        w_oe;
    logic        w_rdy;
    logic [3:0]  w_sio;

    // Nibble p of the 24b byte address {7'b0, a, 1'b0}, most significant first.
    function automatic logic [3:0] addr_nibble(input logic [15:0] a, input logic [2:0] p);
        logic [3:0] n;
        case (p)
            3'd0:    n = 4'h0;
            3'd1:    n = {3'b000, a[15]};
            3'd2:    n = a[14:11];
            3'd3:    n = a[10:7];
            3'd4:    n = a[6:3];
            3'd5:    n = {a[2:0], 1'b0};
            default: n = 4'h0;
        endcase
        return n;
    endfunction

    // Arbitration and next-state sequencing; the phase counter restarts on every state change.
    always_comb begin
        w_nxt_state  = r_state;
        w_grant      = 1'b0;
        w_pick_fetch = bus.i_fetch_req && (!bus.i_data_req || r_last_data);
        case (r_state)
            ST_IDLE: begin
                if (bus.i_fetch_req || bus.i_data_req) begin
                    w_grant     = 1'b1;
                    w_nxt_state = ST_CMD;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (r_phase == 3'd1) w_nxt_state = ST_ADDR;
                else                 w_nxt_state = ST_CMD;
            end
            ST_ADDR: begin
                if (r_phase != 3'd5)                      w_nxt_state = ST_ADDR;
                else if (r_wr || (DUMMY_CYCLES == 0))     w_nxt_state = ST_DATA;
                else                                      w_nxt_state = ST_DUMMY;
            end
            ST_DUMMY: begin
                if (r_phase == DUMMY_LAST) w_nxt_state = ST_DATA;
                else                       w_nxt_state = ST_DUMMY;
            end
            ST_DATA: begin
                if (r_phase == 3'd3) w_nxt_state = ST_END;
                else                 w_nxt_state = ST_DATA;
            end
            ST_END:  w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
        if (w_nxt_state != r_state) w_nxt_phase = 3'd0;
        else                        w_nxt_phase = r_phase + 3'd1;
    end

    // Pin drive decoded from the registered state; write data passes straight through.
    always_comb begin
        w_oe  = 1'b0;
        w_rdy = 1'b0;
        w_sio = 4'h0;
        case (r_state)
            ST_CMD: begin
                w_oe = 1'b1;
                if (r_phase == 3'd0) w_sio = 4'h0;
                else                 w_sio = r_wr ? 4'h2 : 4'h3;
            end
            ST_ADDR: begin
                w_oe  = 1'b1;
                w_sio = addr_nibble(r_addr, r_phase);
            end
            ST_DATA: begin
                if (r_wr) begin
                    w_oe  = 1'b1;
                    w_rdy = 1'b1;
                    w_sio = bus.i_data_wdata;
                end else begin
                    w_oe  = 1'b0;
                    w_rdy = 1'b0;
                    w_sio = 4'h0;
                end
            end
            default: begin
                w_oe  = 1'b0;
                w_rdy = 1'b0;
                w_sio = 4'h0;
            end
        endcase
    end

    assign w_active  = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                       (r_state == ST_DUMMY) || (r_state == ST_DATA);
    assign w_rd_data = (r_state == ST_DATA) && !r_wr;

    // FSM state, grant pulses and the latched transaction of the winning requester.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= 3'd0;
            r_last_data <= 1'b1;
            r_sel_fetch <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= 16'h0000;
            r_fetch_gnt <= 1'b0;
            r_data_gnt  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_phase     <= w_nxt_phase;
            r_fetch_gnt <= w_grant && w_pick_fetch;
            r_data_gnt  <= w_grant && !w_pick_fetch;
            if (w_grant) begin
                r_last_data <= !w_pick_fetch;
                r_sel_fetch <= w_pick_fetch;
                r_wr        <= w_pick_fetch ? 1'b0 : bus.i_data_wr;
                r_addr      <= w_pick_fetch ? bus.i_fetch_addr : bus.i_data_addr;
            end
        end
    end

    // Read slices are captured for the granted requester only, valid one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_vld  <= 1'b0;
            r_data_vld   <= 1'b0;
            r_fetch_data <= 4'h0;
            r_data_rdata <= 4'h0;
        end else begin
            r_fetch_vld <= w_rd_data && r_sel_fetch;
            r_data_vld  <= w_rd_data && !r_sel_fetch;
            if (w_rd_data && r_sel_fetch)  r_fetch_data <= bus.i_sqi_sio;
            if (w_rd_data && !r_sel_fetch) r_data_rdata <= bus.i_sqi_sio;
        end
    end

    assign bus.o_fetch_gnt  = r_fetch_gnt;
    assign bus.o_data_gnt   = r_data_gnt;
    assign bus.o_fetch_vld  = r_fetch_vld;
    assign bus.o_data_vld   = r_data_vld;
    assign bus.o_fetch_data = r_fetch_data;
    assign bus.o_data_rdata = r_data_rdata;
    assign bus.o_data_rdy   = w_rdy;
    assign bus.o_sqi_cs_n   = ~w_active;
    assign bus.o_sqi_sck_en = w_active;
    assign bus.o_sqi_oe     = w_oe;
    assign bus.o_sqi_sio    = w_sio;

endmodule

// File: tb/tb_idli_sqi_arb.sv
// Directed bench for idli_sqi_arb: pin-level phase checks per cycle plus a
// read-slice scoreboard popped whenever a vld strobe appears.
module tb_idli_sqi_arb;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_chk  = 0;
    int   m_pass = 0;
    logic [3:0] fq[$];
    logic [3:0] dq[$];

    idli_sqi_arb_if bus ();

    idli_sqi_arb #(.DUMMY_CYCLES(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: every vld strobe must match the next pending slice of that requester.
    always @(negedge clk) begin
        logic [3:0] e;
        if (bus.o_fetch_vld === 1'b1) begin
            m_chk++;
            if (fq.size() > 0) begin
                e = fq.pop_front();
                assert (bus.o_fetch_data === e) m_pass++;
                else $error("FAIL fetch_rdata: observed %h expected %h", bus.o_fetch_data, e);
            end else begin
                $error("FAIL fetch_vld_unexpected: observed vld=1 expected no pending slice");
            end
        end
        if (bus.o_data_vld === 1'b1) begin
            m_chk++;
            if (dq.size() > 0) begin
                e = dq.pop_front();
                assert (bus.o_data_rdata === e) m_pass++;
                else $error("FAIL data_rdata: observed %h expected %h", bus.o_data_rdata, e);
            end else begin
                $error("FAIL data_vld_unexpected: observed vld=1 expected no pending slice");
            end
        end
    end

    // One full transaction starting in an IDLE cycle; returns in the IDLE cycle after it.
    task automatic txn(input bit is_fetch, input bit is_wr, input logic [15:0] a,
                       input logic [15:0] sl, input bit hold, input int pulse_at);
        logic [3:0] s[4];
        logic [3:0] an[6];
        int last_off;
        int end_off;
        s  = '{sl[15:12], sl[11:8], sl[7:4], sl[3:0]};
        an = '{4'h0, {3'b000, a[15]}, a[14:11], a[10:7], a[6:3], {a[2:0], 1'b0}};
        last_off = is_wr ? 14 : 16;
        end_off  = is_wr ? 13 : 15;
        if (is_fetch) begin
            bus.i_fetch_req  = 1'b1;
            bus.i_fetch_addr = a;
        end else begin
            bus.i_data_req  = 1'b1;
            bus.i_data_wr   = is_wr;
            bus.i_data_addr = a;
        end
        #1;
        chk("idle_cs_n", 16'(bus.o_sqi_cs_n), 16'h1);
        for (int off = 1; off <= last_off; off++) begin
            tick();
            if (pulse_at >= 0 && off == pulse_at)          bus.i_data_req = 1'b1;
            else if (pulse_at >= 0 && off == pulse_at + 1) bus.i_data_req = 1'b0;
            if (!is_wr && off >= 11 && off <= 14) begin
                bus.i_sqi_sio = s[off-11];
                if (is_fetch) fq.push_back(s[off-11]);
                else          dq.push_back(s[off-11]);
            end else begin
                bus.i_sqi_sio = 4'h0;
            end
            if (is_wr && off >= 9 && off <= 12) bus.i_data_wdata = s[off-9];
            else                                bus.i_data_wdata = 4'h0;
            #1;
            chk("cs_n", 16'(bus.o_sqi_cs_n), (off >= end_off) ? 16'h1 : 16'h0);
            chk("sck_en", 16'(bus.o_sqi_sck_en), (off >= end_off) ? 16'h0 : 16'h1);
            if (off == 1) begin
                chk("own_gnt", 16'(is_fetch ? bus.o_fetch_gnt : bus.o_data_gnt), 16'h1);
                chk("other_gnt", 16'(is_fetch ? bus.o_data_gnt : bus.o_fetch_gnt), 16'h0);
                if (!hold) begin
                    if (is_fetch) bus.i_fetch_req = 1'b0;
                    else          bus.i_data_req  = 1'b0;
                end
            end
            if (off == 2) chk("gnt_pulse", 16'(is_fetch ? bus.o_fetch_gnt : bus.o_data_gnt), 16'h0);
            if (off <= 2) begin
                chk("cmd_oe", 16'(bus.o_sqi_oe), 16'h1);
                chk("cmd_sio", 16'(bus.o_sqi_sio), (off == 1) ? 16'h0 : (is_wr ? 16'h2 : 16'h3));
            end else if (off <= 8) begin
                chk("addr_oe", 16'(bus.o_sqi_oe), 16'h1);
                chk("addr_sio", 16'(bus.o_sqi_sio), 16'(an[off-3]));
                chk("addr_rdy", 16'(bus.o_data_rdy), 16'h0);
            end else if (is_wr && off <= 12) begin
                chk("wr_rdy", 16'(bus.o_data_rdy), 16'h1);
                chk("wr_oe", 16'(bus.o_sqi_oe), 16'h1);
                chk("wr_sio", 16'(bus.o_sqi_sio), 16'(s[off-9]));
            end else if (!is_wr && off <= 14) begin
                chk("rd_oe", 16'(bus.o_sqi_oe), 16'h0);
                chk("rd_sio", 16'(bus.o_sqi_sio), 16'h0);
                chk("rd_rdy", 16'(bus.o_data_rdy), 16'h0);
            end else begin
                chk("end_oe", 16'(bus.o_sqi_oe), 16'h0);
                chk("end_rdy", 16'(bus.o_data_rdy), 16'h0);
            end
            if (!is_wr) begin
                chk("own_vld", 16'(is_fetch ? bus.o_fetch_vld : bus.o_data_vld),
                    (off >= 12 && off <= 15) ? 16'h1 : 16'h0);
                chk("other_vld", 16'(is_fetch ? bus.o_data_vld : bus.o_fetch_vld), 16'h0);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.i_fetch_req  = 1'b0;
        bus.i_fetch_addr = 16'h0000;
        bus.i_data_req   = 1'b0;
        bus.i_data_wr    = 1'b0;
        bus.i_data_addr  = 16'h0000;
        bus.i_data_wdata = 4'h0;
        bus.i_sqi_sio    = 4'h0;
        tick();
        tick();
        chk("rst_cs_n", 16'(bus.o_sqi_cs_n), 16'h1);
        chk("rst_outs", {4'h0, bus.o_fetch_gnt, bus.o_data_gnt, bus.o_fetch_vld, bus.o_data_vld,
                         bus.o_data_rdy, bus.o_sqi_sck_en, bus.o_sqi_oe, 1'b0, bus.o_sqi_sio}, 16'h0000);
        chk("rst_rdata", {8'h00, bus.o_fetch_data, bus.o_data_rdata}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Tie straight out of reset: fetch wins, data follows at the next IDLE.
        bus.i_data_req  = 1'b1;
        bus.i_data_wr   = 1'b1;
        bus.i_data_addr = 16'h8001;
        txn(1'b1, 1'b0, 16'h1234, 16'hDCBA, 1'b0, -1);
        txn(1'b0, 1'b1, 16'h8001, 16'h5A5A, 1'b0, -1);

        // Second tie goes back to fetch; then back-to-back data reads with req held.
        bus.i_data_req  = 1'b1;
        bus.i_data_wr   = 1'b0;
        bus.i_data_addr = 16'hBEEF;
        txn(1'b1, 1'b0, 16'h00FF, 16'h1357, 1'b0, -1);
        txn(1'b0, 1'b0, 16'hBEEF, 16'h9E3C, 1'b1, -1);
        txn(1'b0, 1'b0, 16'h0F0F, 16'h2468, 1'b0, -1);

        // Reset in the middle of ADDR.
        bus.i_fetch_req  = 1'b1;
        bus.i_fetch_addr = 16'h4321;
        tick();
        bus.i_fetch_req = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_cs_n", 16'(bus.o_sqi_cs_n), 16'h0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", 16'(bus.o_sqi_cs_n), 16'h1);
        chk("async_rst_oe", 16'(bus.o_sqi_oe), 16'h0);
        chk("async_rst_sio", 16'(bus.o_sqi_sio), 16'h0);
        chk("async_rst_sck", 16'(bus.o_sqi_sck_en), 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        txn(1'b1, 1'b0, 16'h0ABC, 16'h7F01, 1'b0, -1);

        // Data request pulsed during the DATA phase of a fetch is dropped.
        txn(1'b1, 1'b0, 16'hFFFE, 16'hE6B2, 1'b0, 12);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("pulse_no_gnt", 16'(bus.o_data_gnt), 16'h0);
            chk("pulse_idle_cs_n", 16'(bus.o_sqi_cs_n), 16'h1);
        end

        tick();
        chk("fetch_q_empty", 16'(fq.size()), 16'h0);
        chk("data_q_empty", 16'(dq.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass + m_pass, n_chk + m_chk);
        $finish;
    end

endmodule
